// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the AXI interconnect read path.
package axi_ic_pkg;

    localparam int NUM_RD_MASTERS = 3;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_arb_state_t;

    typedef logic [NUM_RD_MASTERS-1:0] grant_t;

    // Pretend master 2 was granted last so that master 0 wins first under round-robin.
    localparam grant_t LAST_GRANT_RST = 3'b100;

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational winner selection: round-robin after the last grant, or fixed m0>m1>m2.
module axi_rr_pick
    import axi_ic_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  grant_t req,
    input  grant_t last,
    output grant_t gnt
);

    logic [1:0] start;
    logic [5:0] req_dbl;
    logic [5:0] pick_dbl;
    grant_t     req_rot;
    grant_t     pick_rot;

    // Rotate requests so the master after 'last' sits at bit 0, take the lowest set bit,
    // then rotate the one-hot result back into master order.
    always_comb begin
        unique case (last)
            3'b001:  start = 2'd1;
            3'b010:  start = 2'd2;
            default: start = 2'd0;
        endcase
        req_dbl  = {req, req} >> start;
        req_rot  = req_dbl[2:0];
        pick_rot = req_rot & (~req_rot + 3'd1);
        pick_dbl = {pick_rot, pick_rot} << start;
    end

    always_comb begin
        if (RR_EN) begin
            gnt = pick_dbl[5:3];
        end else begin
            gnt = req & (~req + 3'd1);
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Three-master AR arbiter: the one-hot grant is locked from selection through the AR
// handshake and the whole R burst, so R routing can follow the same grant.
module axi_read_arbiter
    import axi_ic_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic m0_ARVALID,
    input  logic m1_ARVALID,
    input  logic m2_ARVALID,
    input  logic arvalid,
    input  logic arready,
    input  logic rvalid,
    input  logic rready,
    input  logic rlast,
    output logic m0_rgrnt,
    output logic m1_rgrnt,
    output logic m2_rgrnt,
    output logic rd_busy
);

    rd_arb_state_t state_q, state_d;
    grant_t        grant_q, grant_d;
    grant_t        last_q, last_d;
    logic          busy_q, busy_d;

    grant_t        req;
    grant_t        pick_last;
    grant_t        pick_gnt;
    logic          ar_hs;
    logic          r_last_hs;

    assign req       = {m2_ARVALID, m1_ARVALID, m0_ARVALID};
    assign ar_hs     = arvalid && arready;
    assign r_last_hs = rvalid && rready && rlast;

    // At the end of a burst the current winner becomes 'last' in the same cycle it re-arbitrates.
    assign pick_last = (state_q == RD_DATA) ? grant_q : last_q;

    axi_rr_pick #(
        .RR_EN(RR_EN)
    ) u_pick (
        .req (req),
        .last(pick_last),
        .gnt (pick_gnt)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            RD_IDLE: begin
                if (|req) begin
                    grant_d = pick_gnt;
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_last_hs) begin
                    last_d = grant_q;
                    if (|req) begin
                        grant_d = pick_gnt;
                        state_d = RD_ADDR;
                    end else begin
                        grant_d = '0;
                        state_d = RD_IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = RD_IDLE;
            end
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RD_IDLE;
            grant_q <= '0;
            last_q  <= LAST_GRANT_RST;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign m0_rgrnt = grant_q[0];
    assign m1_rgrnt = grant_q[1];
    assign m2_rgrnt = grant_q[2];
    assign rd_busy  = busy_q;

endmodule
